// File: rtl/angle_counter.sv
// Phase-angle generator: 12-bit accumulator stepping by STEP each CLK_16 edge, with quadrant-crossing pulse and cycle counter.
// Optional build macro ANGLECOUNTER_SYNC_CLR_EN makes countclk restart at 0 on every phase wrap.
module angle_counter #(
  parameter int STEP = 1
) (
  input  logic        CLK_16,
  input  logic        RST_N,
  output logic        Quad_Change,
  output logic [11:0] OUTF,
  output logic [15:0] countclk
);

  localparam logic [11:0] STEP_W = 12'(STEP);

  logic [11:0] outf_next;

  // 12-bit add: the carry out is discarded so the circle wraps silently
  assign outf_next = OUTF + STEP_W;

  always_ff @(posedge CLK_16 or negedge RST_N) begin
    if (!RST_N) begin
      OUTF        <= '0;
      Quad_Change <= 1'b0;
      countclk    <= '0;
    end else begin
      OUTF        <= outf_next;
      Quad_Change <= (outf_next[11:10] != OUTF[11:10]);
`ifdef ANGLECOUNTER_SYNC_CLR_EN
      // a smaller next angle means the accumulator wrapped this edge
      countclk    <= (outf_next < OUTF) ? 16'd0 : countclk + 16'd1;
`else
      countclk    <= countclk + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_angle_counter.sv
// Self-checking bench for angle_counter: four STEP variants share one clock/reset and are compared each edge
// against an arithmetic reference model, with directed checks on the spec's landmark values.
module tb_angle_counter;

  localparam int N = 4;
  localparam int STEPS [N] = '{1, 1500, 2048, 700};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        qc   [N];
  logic [11:0] outf [N];
  logic [15:0] cnt  [N];

  int tests = 0;
  int fails = 0;

  // reference state
  int m_phase [N];
  int m_qc    [N];
  int m_cnt   [N];

  always #10 clk = ~clk;

  angle_counter #(.STEP(1))    u0 (.CLK_16(clk), .RST_N(rst_n), .Quad_Change(qc[0]), .OUTF(outf[0]), .countclk(cnt[0]));
  angle_counter #(.STEP(1500)) u1 (.CLK_16(clk), .RST_N(rst_n), .Quad_Change(qc[1]), .OUTF(outf[1]), .countclk(cnt[1]));
  angle_counter #(.STEP(2048)) u2 (.CLK_16(clk), .RST_N(rst_n), .Quad_Change(qc[2]), .OUTF(outf[2]), .countclk(cnt[2]));
  angle_counter #(.STEP(700))  u3 (.CLK_16(clk), .RST_N(rst_n), .Quad_Change(qc[3]), .OUTF(outf[3]), .countclk(cnt[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_phase[i] = 0;
      m_qc[i]    = 0;
      m_cnt[i]   = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s outf[%0d]", tag, i), 32'(outf[i]), 32'(m_phase[i]));
      chk($sformatf("%s qc[%0d]", tag, i),   32'(qc[i]),   32'(m_qc[i]));
      chk($sformatf("%s cnt[%0d]", tag, i),  32'(cnt[i]),  32'(m_cnt[i]));
    end
  endtask

  // one rising edge: advance the model by the spec's rules, then compare
  task automatic tick(input string tag);
    int old;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      old        = m_phase[i];
      m_phase[i] = (old + STEPS[i]) % 4096;
      m_qc[i]    = ((m_phase[i] / 1024) != (old / 1024)) ? 1 : 0;
`ifdef ANGLECOUNTER_SYNC_CLR_EN
      m_cnt[i]   = (m_phase[i] < old) ? 0 : m_cnt[i] + 1;
`else
      m_cnt[i]   = (m_cnt[i] + 1) % 65536;
`endif
    end
    check_all(tag);
  endtask

  task automatic zeros(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s outf[%0d]", tag, i), 32'(outf[i]), 32'd0);
      chk($sformatf("%s qc[%0d]", tag, i),   32'(qc[i]),   32'd0);
      chk($sformatf("%s cnt[%0d]", tag, i),  32'(cnt[i]),  32'd0);
    end
  endtask

  int seq1500 [8] = '{1500, 3000, 404, 1904, 3404, 808, 2308, 3808};
  int pulses;
  int run_len;
  int hold;

  initial begin
    model_reset();

    // reset hold, 5 cycles
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      zeros("reset_hold");
    end

    // release and run one full revolution of STEP=1
    rst_n  = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 4096; n++) begin
      tick("rev");
      if (n == 1) chk("edge1 outf700", 32'(outf[3]), 32'd700);
      if (n <= 1023) chk("q1 count", 32'(cnt[0]), 32'(n));
      if (n == 1024) begin
        chk("q1 outf1024", 32'(outf[0]), 32'd1024);
        chk("q1 pulse",    32'(qc[0]),   32'd1);
      end
      if (n <= 8) begin
        chk("s1500 outf", 32'(outf[1]), 32'(seq1500[n-1]));
        chk("s1500 qc",   32'(qc[1]),   32'd1);
      end
      chk("s2048 outf", 32'(outf[2]), (n % 2) ? 32'd2048 : 32'd0);
      chk("s2048 qc",   32'(qc[2]),   32'd1);
      if (qc[0]) pulses++;
    end
    chk("rev pulses", 32'(pulses), 32'd4);
    chk("rev wrap outf", 32'(outf[0]), 32'd0);
    chk("rev wrap qc",   32'(qc[0]),   32'd1);
`ifdef ANGLECOUNTER_SYNC_CLR_EN
    chk("rev cnt", 32'(cnt[0]), 32'd0);
`else
    chk("rev cnt", 32'(cnt[0]), 32'd4096);
`endif

    // randomized mid-count asynchronous reset
    run_len = $urandom_range(10, 3000);
    for (int n = 0; n < run_len; n++) tick("rand_run");
    #4;
    rst_n = 1'b0;
    #1;
    zeros("async_reset");
    model_reset();
    hold = $urandom_range(1, 3);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      zeros("reset_hold2");
    end
    rst_n = 1'b1;

    // long run covering the 16-bit counter wrap
    for (int n = 1; n <= 65537; n++) begin
      tick("long");
`ifndef ANGLECOUNTER_SYNC_CLR_EN
      if (n == 65535) chk("cnt 65535", 32'(cnt[0]), 32'd65535);
      if (n == 65536) begin
        chk("cnt wrap", 32'(cnt[0]), 32'd0);
        chk("cnt wrap outf", 32'(outf[0]), 32'd0);
      end
`endif
      if (n == 1) chk("restart no pulse", 32'(qc[0]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
